// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM state encoding, lane count and access-legality helpers for the LSU
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam int LANES = 4;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  function automatic logic legal(input logic we, input logic [2:0] f3);
    return we ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
              : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
  endfunction
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return f3[1:0] == 2'b01 ? off[0] : f3[1:0] == 2'b10 ? off != 2'b00 : 1'b0;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte enables, lane-replicated store data from (st_funct3, st_off, st_wdata); extended load data from (ld_funct3, ld_off, rdata)
module lsu_align import lsu_pkg::*; (
  input  logic [2:0]       st_funct3,
  input  logic [1:0]       st_off,
  input  logic [31:0]      st_wdata,
  input  logic [2:0]       ld_funct3,
  input  logic [1:0]       ld_off,
  input  logic [31:0]      rdata,
  output logic [LANES-1:0] be,
  output logic [31:0]      wdata,
  output logic [31:0]      ld_data
);
  logic [31:0] sh;
  always_comb begin
    be = st_funct3[1:0] == 2'b00 ? 4'b0001 << st_off
       : st_funct3[1:0] == 2'b01 ? 4'b0011 << st_off : 4'b1111;
    wdata = st_funct3[1:0] == 2'b00 ? {4{st_wdata[7:0]}}
          : st_funct3[1:0] == 2'b01 ? {2{st_wdata[15:0]}} : st_wdata;
    sh = rdata >> {ld_off, 3'b000};
    ld_data = ld_funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]}
            : ld_funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]}
            : ld_funct3 == F3_BU ? {24'b0, sh[7:0]}
            : ld_funct3 == F3_HU ? {16'b0, sh[15:0]} : sh;
  end
endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store unit; core req (req_*) -> memory req/gnt/rvalid (mem_*) -> one-cycle response (rsp_*)
module lsu_mem_port import lsu_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LANES-1:0]  mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t state, state_n;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic we_q, bad, accept, done;
  logic [LANES-1:0] be;
  logic [DATA_W-1:0] wdata_al, ld_data;
  lsu_align u_align (
    .st_funct3(req_funct3),
    .st_off(req_addr[1:0]),
    .st_wdata(req_wdata),
    .ld_funct3(f3_q),
    .ld_off(off_q),
    .rdata(mem_rdata),
    .be(be),
    .wdata(wdata_al),
    .ld_data(ld_data)
  );
  assign bad = !legal(req_we, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
  assign accept = state == IDLE && req_valid;
  assign done = mem_rvalid && (state == WAIT || (state == REQ && mem_gnt));
  always_comb begin
    state_n = state;
    req_ready = 1'b0;
    mem_req = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        state_n = req_valid && !bad ? REQ : IDLE;
      end
      REQ: begin
        mem_req = 1'b1;
        state_n = mem_gnt ? (mem_rvalid ? IDLE : WAIT) : REQ;
      end
      WAIT: state_n = mem_rvalid ? IDLE : WAIT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
      f3_q <= '0;
      off_q <= '0;
      we_q <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_be <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_n;
      rsp_valid <= (accept && bad) || done;
      rsp_err <= accept && bad;
      rsp_rdata <= done && !we_q ? ld_data : '0;
      if (accept && !bad) begin
        f3_q <= req_funct3;
        off_q <= req_addr[1:0];
        we_q <= req_we;
        mem_we <= req_we;
        mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
        mem_be <= be;
        mem_wdata <= wdata_al;
      end
    end
  end
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed self-checking bench for lsu_mem_port
module tb_lsu_mem_port;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [2:0] req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
  logic req_ready, rsp_valid, rsp_err, mem_req, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  lsu_mem_port dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    tick;
    req_valid = 1'b0;
  endtask
  task automatic finish_mem(input logic [31:0] rd);
    mem_gnt = 1'b1;
    tick;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd;
    tick;
    mem_rvalid = 1'b0;
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %0h want 1", req_ready); end
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got %0h want 0", mem_req); end
    n_cmp++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp got %0h%0h want 00", rsp_valid, rsp_err); end
    n_cmp++; if (mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0 || mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_bus got %h %h %h %0h want 0", mem_addr, mem_be, mem_wdata, mem_we); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", rsp_rdata); end
    rst_n = 1'b1;
  endtask
  task automatic test_lw;
    issue(1'b0, 3'b010, 32'h100, 32'h0);
    n_cmp++; if (mem_req !== 1'b1 || req_ready !== 1'b0) begin n_err++; $display("FAIL lw_req got req=%0h rdy=%0h want 1 0", mem_req, req_ready); end
    n_cmp++; if (mem_addr !== 32'h100 || mem_be !== 4'hF || mem_we !== 1'b0) begin n_err++; $display("FAIL lw_bus got %h %h %0h want 00000100 f 0", mem_addr, mem_be, mem_we); end
    mem_gnt = 1'b1;
    tick;
    mem_gnt = 1'b0;
    n_cmp++; if (mem_req !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin n_err++; $display("FAIL lw_wait got req=%0h v=%0h rdy=%0h want 0 0 0", mem_req, rsp_valid, req_ready); end
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick;
    mem_rvalid = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_rsp got %0h %0h %h want 1 0 deadbeef", rsp_valid, rsp_err, rsp_rdata); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL lw_ready_on_rsp got %0h want 1", req_ready); end
    tick;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL lw_pulse got %0h want 0", rsp_valid); end
  endtask
  task automatic test_load_ext;
    logic [2:0] f3 [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    logic [31:0] ad [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
    logic [31:0] rd [5] = '{32'h80112233, 32'h80112233, 32'h80012233, 32'h80012233, 32'h8011227F};
    logic [31:0] ex [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'h0000007F};
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, f3[i], ad[i], 32'h0);
      n_cmp++; if (mem_addr !== {ad[i][31:2], 2'b00}) begin n_err++; $display("FAIL ld%0d_addr got %h want %h", i, mem_addr, {ad[i][31:2], 2'b00}); end
      if (i % 2 == 1) begin
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = rd[i];
        tick;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
      end else finish_mem(rd[i]);
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== ex[i]) begin n_err++; $display("FAIL ld%0d_rsp got %0h %0h %h want 1 0 %h", i, rsp_valid, rsp_err, rsp_rdata, ex[i]); end
    end
    tick;
  endtask
  task automatic test_store;
    logic [2:0] f3 [3] = '{3'b000, 3'b001, 3'b010};
    logic [31:0] ad [3] = '{32'h101, 32'h102, 32'h104};
    logic [31:0] wd [3] = '{32'h123456AB, 32'hCAFEBEEF, 32'h01020304};
    logic [3:0] eb [3] = '{4'b0010, 4'b1100, 4'b1111};
    logic [31:0] ew [3] = '{32'hABABABAB, 32'hBEEFBEEF, 32'h01020304};
    logic [31:0] ea [3] = '{32'h100, 32'h100, 32'h104};
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, f3[i], ad[i], wd[i]);
      n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== ea[i]) begin n_err++; $display("FAIL st%0d_req got %0h %0h %h want 1 1 %h", i, mem_req, mem_we, mem_addr, ea[i]); end
      n_cmp++; if (mem_be !== eb[i] || mem_wdata !== ew[i]) begin n_err++; $display("FAIL st%0d_lanes got %b %h want %b %h", i, mem_be, mem_wdata, eb[i], ew[i]); end
      finish_mem(32'h55555555);
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin n_err++; $display("FAIL st%0d_rsp got %0h %0h %h want 1 0 0", i, rsp_valid, rsp_err, rsp_rdata); end
    end
    tick;
  endtask
  task automatic test_errors;
    logic we [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0] f3 [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
    logic [31:0] ad [4] = '{32'h102, 32'h101, 32'h100, 32'h100};
    mem_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      issue(we[i], f3[i], ad[i], 32'hFFFFFFFF);
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin n_err++; $display("FAIL err%0d_rsp got %0h %0h %h want 1 1 0", i, rsp_valid, rsp_err, rsp_rdata); end
      n_cmp++; if (mem_req !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL err%0d_idle got req=%0h rdy=%0h want 0 1", i, mem_req, req_ready); end
      tick;
      n_cmp++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || mem_req !== 1'b0) begin n_err++; $display("FAIL err%0d_after got %0h %0h %0h want 0 0 0", i, rsp_valid, rsp_err, mem_req); end
    end
  endtask
  task automatic test_gnt_delay;
    issue(1'b1, 3'b001, 32'h206, 32'h0000A5C3);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h300; req_wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = (i == 1);
      mem_rdata = 32'h77777777;
      tick;
      n_cmp++; if (mem_req !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL dly%0d_ctl got req=%0h rdy=%0h v=%0h want 1 0 0", i, mem_req, req_ready, rsp_valid); end
      n_cmp++; if (mem_addr !== 32'h204 || mem_be !== 4'b1100 || mem_wdata !== 32'hA5C3A5C3 || mem_we !== 1'b1) begin n_err++; $display("FAIL dly%0d_bus got %h %b %h %0h want 00000204 1100 a5c3a5c3 1", i, mem_addr, mem_be, mem_wdata, mem_we); end
    end
    mem_rvalid = 1'b0; req_valid = 1'b0;
    finish_mem(32'h12345678);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin n_err++; $display("FAIL dly_rsp got %0h %h want 1 0", rsp_valid, rsp_rdata); end
    tick;
    n_cmp++; if (mem_req !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL dly_no_extra got req=%0h v=%0h want 0 0", mem_req, rsp_valid); end
  endtask
  task automatic test_reset_mid;
    issue(1'b0, 3'b010, 32'h400, 32'h0);
    mem_gnt = 1'b1;
    tick;
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1 || mem_req !== 1'b0 || mem_addr !== 32'h0 || mem_be !== 4'h0) begin n_err++; $display("FAIL rstmid_outs got rdy=%0h req=%0h %h %b want 1 0 0 0", req_ready, mem_req, mem_addr, mem_be); end
    #2;
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hAAAA5555;
    tick;
    mem_rvalid = 1'b0;
    tick;
    n_cmp++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin n_err++; $display("FAIL rstmid_late got %0h %h want 0 0", rsp_valid, rsp_rdata); end
    issue(1'b0, 3'b010, 32'h104, 32'h0);
    finish_mem(32'h01234567);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h01234567) begin n_err++; $display("FAIL rstmid_next got %0h %0h %h want 1 0 01234567", rsp_valid, rsp_err, rsp_rdata); end
  endtask
  initial begin
    test_reset;
    test_lw;
    test_load_ext;
    test_store;
    test_errors;
    test_gnt_delay;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
